// File: rtl/timer_irq.sv
// Memory-mapped machine timer: prescaled counter, compare match, latched pending
// flag and a registered level interrupt, programmed over a req/ack register bus.
module timer_irq #(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  // Bus handshake: req_i is a one-cycle request (we_i qualifies it); every request
  // sampled at an edge is answered by a one-cycle ack_o after that edge, with
  // data_o carrying the pre-edge register value for reads and 0 otherwise.

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_CMP   = 2'd2;
  localparam logic [1:0] ADDR_PRESC = 2'd3;

  logic                  en;
  logic                  ie;
  logic                  pend;
  logic                  periodic;
  logic [31:0]           count;
  logic [31:0]           cmp;
  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] pc;

  logic                  wr;
  logic                  wr_ctrl;
  logic                  wr_count;
  logic                  wr_cmp;
  logic                  wr_presc;
  logic                  tick;
  logic                  match;
  logic                  en_next;
  logic [31:0]           rd_data;

  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

  always_comb begin
    wr       = req_i & we_i;
    wr_ctrl  = wr && (addr_i[3:2] == ADDR_CTRL);
    wr_count = wr && (addr_i[3:2] == ADDR_COUNT);
    wr_cmp   = wr && (addr_i[3:2] == ADDR_CMP);
    wr_presc = wr && (addr_i[3:2] == ADDR_PRESC);

    tick  = en && (pc == presc);
    // Compare always uses the CMP value from before this edge.
    match = tick && (count == cmp);

    // A CTRL write overrides the one-shot auto-disable.
    en_next = en;
    if (match && !periodic) en_next = 1'b0;
    if (wr_ctrl)            en_next = data_i[0];

    rd_data = '0;
    case (addr_i[3:2])
      ADDR_CTRL:  rd_data = {28'd0, periodic, pend, ie, en};
      ADDR_COUNT: rd_data = count;
      ADDR_CMP:   rd_data = cmp;
      default:    rd_data = 32'(presc);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      pend      <= 1'b0;
      periodic  <= 1'b0;
      count     <= '0;
      cmp       <= '0;
      presc     <= '0;
      pc        <= '0;
      ack_o     <= 1'b0;
      data_o    <= '0;
      int_sig_o <= 1'b0;
    end else begin
      en <= en_next;

      if (wr_ctrl) begin
        ie       <= data_i[1];
        periodic <= data_i[3];
      end

      // A match setting pend beats a W1C clear in the same cycle.
      if (match)                     pend <= 1'b1;
      else if (wr_ctrl && data_i[2]) pend <= 1'b0;

      if (wr_count)     count <= data_i;
      else if (match)   count <= periodic ? 32'd0 : count;
      else if (tick)    count <= count + 32'd1;

      if (wr_cmp)   cmp   <= data_i;
      if (wr_presc) presc <= data_i[PRESCALE_W-1:0];

      // Prescaler restarts on a tick, on a COUNT write, and whenever the timer is off.
      if (wr_count || !en || !en_next || tick) pc <= '0;
      else                                     pc <= pc + 1'b1;

      int_sig_o <= pend & ie;
      ack_o     <= req_i;
      data_o    <= (req_i && !we_i) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Randomized and directed bench for timer_irq: a reference model predicts every
// bus response and the interrupt level; a monitor checks them against the DUT.
module tb_timer_irq;

  localparam int PW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        int_sig;

  always #5 clk = ~clk;

  timer_irq #(.PRESCALE_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .data_i    (wdata),
    .ack_o     (ack),
    .data_o    (rdata),
    .int_sig_o (int_sig)
  );

  // Reference model state
  logic          m_en = 0, m_ie = 0, m_pend = 0, m_per = 0;
  logic [31:0]   m_count = 0, m_cmp = 0;
  logic [PW-1:0] m_presc = 0, m_pc = 0;
  logic          m_ack = 0, m_int = 0;

  logic [32:0] exp_q[$];   // {is_read, expected read data}
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_per, m_pend, m_ie, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return 32'(m_presc);
    endcase
  endfunction

  function automatic bit model_will_match();
    return m_en && (m_pc == m_presc) && (m_count == m_cmp);
  endfunction

  // Model: apply the timer rules first, then let bus writes override them.
  always @(posedge clk) begin : model
    bit tick, match;
    logic [31:0] rd;
    if (rst) begin
      m_en = 0; m_ie = 0; m_pend = 0; m_per = 0;
      m_count = 0; m_cmp = 0; m_presc = 0; m_pc = 0;
      m_ack = 0; m_int = 0;
    end else begin
      rd    = model_read(addr[3:2]);
      m_int = m_pend & m_ie;
      tick  = m_en && (m_pc == m_presc);
      match = tick && (m_count == m_cmp);
      if (tick) begin
        m_pc = 0;
        if (match) begin
          m_pend = 1;
          if (m_per) m_count = 0;
          else       m_en = 0;
        end else begin
          m_count = m_count + 1;
        end
      end else if (m_en) begin
        m_pc = m_pc + 1;
      end
      if (req && we) begin
        case (addr[3:2])
          2'd0: begin
            m_en = wdata[0]; m_ie = wdata[1]; m_per = wdata[3];
            if (wdata[2] && !match) m_pend = 0;
          end
          2'd1: begin m_count = wdata; m_pc = 0; end
          2'd2: m_cmp = wdata;
          default: m_presc = wdata[PW-1:0];
        endcase
      end
      if (!m_en) m_pc = 0;
      m_ack = req;
      if (req) exp_q.push_back({~we, (we ? 32'd0 : rd)});
    end
  end

  // Monitor: compare outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (chk_en) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("int_sig", 32'(int_sig), 32'(m_int));
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("ack_without_request", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) check("read_data", rdata, e[31:0]);
        end
      end else begin
        check("data_idle", rdata, 32'd0);
        if (exp_q.size() != 0) begin
          check("ack_missing", 32'(ack), 32'd1);
          exp_q.delete();
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    req = 1; we = 1; addr = $urandom(); addr[3:2] = a; wdata = d;
    @(negedge clk);
    req = 0; we = 0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    req = 1; we = 0; addr = $urandom(); addr[3:2] = a; wdata = $urandom();
    @(negedge clk);
    req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cycles_to_int(output int k);
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (int_sig === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    bit hit;
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_int", 32'(int_sig), 32'd0);
    rst = 0;

    // 1: one-shot match, interrupt one edge after pend
    bus_write(3, 0);
    bus_write(2, 5);
    bus_write(0, 32'h3);
    cycles_to_int(k);
    check("t1_int_latency", 32'(k), 32'd7);
    bus_read(0);
    bus_read(1);

    // 2: periodic with prescaler 3
    bus_write(0, 32'h4);
    bus_write(1, 0);
    bus_write(3, 3);
    bus_write(2, 2);
    idle(2);
    bus_write(0, 32'hB);
    cycles_to_int(k);
    check("t2_match_edge", 32'(k), 32'd13);
    bus_read(1);

    // 3: W1C on the exact match cycle, then on a quiet cycle
    hit = 0;
    for (int i = 0; i < 30; i++) begin
      if (model_will_match()) begin
        bus_write(0, 32'hF);
        hit = 1;
        break;
      end
      idle(1);
    end
    check("t3_match_found", 32'(hit), 32'd1);
    check("t3_int_held", 32'(int_sig), 32'd1);
    idle(3);
    bus_write(0, 32'hF);
    idle(1);
    check("t3_int_cleared", 32'(int_sig), 32'd0);

    // 4: masked pending, then unmask
    bus_write(0, 32'h4);
    bus_write(1, 0);
    bus_write(3, 0);
    bus_write(2, 3);
    bus_write(0, 32'h1);
    idle(8);
    bus_read(0);
    check("t4_int_masked", 32'(int_sig), 32'd0);
    bus_write(0, 32'h3);
    idle(1);
    check("t4_int_unmasked", 32'(int_sig), 32'd1);

    // 5: wrap through 0xFFFFFFFF without a match
    bus_write(0, 32'h4);
    bus_write(3, 0);
    bus_write(1, 32'hFFFF_FFFE);
    bus_write(2, 1);
    bus_write(0, 32'h3);
    repeat (6) bus_read(1);
    bus_read(0);

    // 6: back-to-back reads, then reset mid-count
    req = 1; we = 0;
    for (int a = 0; a < 4; a++) begin
      addr = 32'(a) << 2;
      @(negedge clk);
    end
    req = 0;
    bus_write(2, 100);
    bus_write(0, 32'hB);
    idle(5);
    rst = 1;
    @(negedge clk);
    check("t6_ack_after_rst", 32'(ack), 32'd0);
    check("t6_int_after_rst", 32'(int_sig), 32'd0);
    rst = 0;
    req = 1; we = 0;
    for (int a = 0; a < 4; a++) begin
      addr = 32'(a) << 2;
      @(negedge clk);
    end
    req = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      req = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 3) == 0);
      addr = $urandom();
      case (addr[3:2])
        2'd0: wdata = $urandom_range(0, 15);
        2'd1, 2'd2: wdata = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                         : $urandom_range(0, 12);
        default: wdata = $urandom_range(0, 3);
      endcase
      @(negedge clk);
    end
    rst = 0; req = 0; we = 0;
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
